// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: opcodes, handshake FSM states,
// default widths and a small alignment helper.
package mem_stage_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int REG_W_DEF   = 6;
   localparam int COND_W_DEF  = 4;
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      OP_ALU    = 2'b00,
      OP_LOAD   = 2'b01,
      OP_STORE  = 2'b10,
      OP_BRANCH = 2'b11
   } op_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   function automatic logic word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ack sequencer: holds the request stable until ack or until the
// wait counter expires, and reports completion or timeout for one cycle.
module dmem_handshake
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              start_we,
   input  logic [DATA_W-1:0] start_addr,
   input  logic [DATA_W-1:0] start_wdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [DATA_W-1:0] rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
   logic               we_reg;
   logic [DATA_W-1:0]  addr_reg, wdata_reg;

   assign cnt_inc = cnt_reg + 1'b1;

   // Ack is tested before the counter so a same-cycle ack beats the timeout.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      done       = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_ACCESS;
               cnt_next   = '0;
            end
         end
         ST_ACCESS: begin
            if (dmem_ack) begin
               done       = 1'b1;
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               timeout    = 1'b1;
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == ST_IDLE && start) begin
            we_reg    <= start_we;
            addr_reg  <= start_addr;
            wdata_reg <= start_wdata;
         end
      end
   end

   // Request is decoded from the state register so an async reset drops it at once.
   assign dmem_req   = (state_reg == ST_ACCESS);
   assign busy       = (state_reg == ST_ACCESS);
   assign dmem_we    = we_reg;
   assign dmem_addr  = addr_reg;
   assign dmem_wdata = wdata_reg;
   assign rdata      = dmem_rdata;

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: condition register, branch resolution, alignment check and the
// registered writeback / branch / error outputs around the dmem handshake.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_W   = REG_W_DEF,
   parameter int COND_W  = COND_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [1:0]        ex_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] new_pc,
   input  logic [REG_W-1:0]  rd_in,
   input  logic [COND_W-1:0] branch_in,
   input  logic              set_cond,
   input  logic [COND_W-1:0] cond_in,
   output logic [COND_W-1:0] alu_cond,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_W-1:0]  wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_target,
   output logic              mem_err
);

   op_e                op;
   logic               accept, is_mem, aligned, start;
   logic               busy, done, timeout;
   logic [DATA_W-1:0]  rdata;
   logic [COND_W-1:0]  cond_hit;

   logic [COND_W-1:0]  cond_reg;
   logic               wb_valid_reg, wb_we_reg, br_taken_reg, mem_err_reg;
   logic [REG_W-1:0]   wb_rd_reg, pend_rd_reg;
   logic [DATA_W-1:0]  wb_data_reg, br_target_reg;
   logic               pend_load_reg;

   assign op       = op_e'(ex_op);
   assign ex_ready = ~busy;
   assign accept   = ex_valid & ex_ready;
   assign is_mem   = (op == OP_LOAD) || (op == OP_STORE);
   assign aligned  = word_aligned(alu_result[1:0]);
   assign start    = accept & is_mem & aligned;

   // Branch compares against the pre-update register, even when set_cond accompanies it.
   genvar gi;
   generate
      for (gi = 0; gi < COND_W; gi++) begin : g_cond_hit
         assign cond_hit[gi] = branch_in[gi] & cond_reg[gi];
      end
   endgenerate

   dmem_handshake #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) u_handshake (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_we    (op == OP_STORE),
      .start_addr  (alu_result),
      .start_wdata (store_data),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .rdata       (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cond_reg      <= '0;
         wb_valid_reg  <= 1'b0;
         wb_we_reg     <= 1'b0;
         wb_rd_reg     <= '0;
         wb_data_reg   <= '0;
         br_taken_reg  <= 1'b0;
         br_target_reg <= '0;
         mem_err_reg   <= 1'b0;
         pend_rd_reg   <= '0;
         pend_load_reg <= 1'b0;
      end else begin
         wb_valid_reg <= 1'b0;
         br_taken_reg <= 1'b0;
         mem_err_reg  <= 1'b0;
         if (accept) begin
            if (set_cond) cond_reg <= cond_in;
            case (op)
               OP_ALU: begin
                  wb_valid_reg <= 1'b1;
                  wb_data_reg  <= alu_result;
                  wb_rd_reg    <= rd_in;
                  wb_we_reg    <= (rd_in != '0);
               end
               OP_BRANCH: begin
                  br_taken_reg  <= |cond_hit;
                  br_target_reg <= new_pc;
               end
               default: begin
                  if (!aligned) begin
                     mem_err_reg <= 1'b1;
                  end else begin
                     pend_rd_reg   <= rd_in;
                     pend_load_reg <= (op == OP_LOAD);
                  end
               end
            endcase
         end
         // done/timeout only occur while busy, so they never overlap an accept.
         if (done) begin
            wb_valid_reg <= 1'b1;
            wb_rd_reg    <= pend_rd_reg;
            wb_we_reg    <= pend_load_reg && (pend_rd_reg != '0);
            if (pend_load_reg) wb_data_reg <= rdata;
         end
         if (timeout) mem_err_reg <= 1'b1;
      end
   end

   assign alu_cond  = cond_reg;
   assign wb_valid  = wb_valid_reg;
   assign wb_we     = wb_we_reg;
   assign wb_rd     = wb_rd_reg;
   assign wb_data   = wb_data_reg;
   assign br_taken  = br_taken_reg;
   assign br_target = br_target_reg;
   assign mem_err   = mem_err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a transaction-level
// model of the condition register, writeback, branch and memory timeout rules.
module tb_mem_access_stage;

   localparam int TIMEOUT = 15;
   localparam logic [1:0] ALU = 2'd0, LOAD = 2'd1, STORE = 2'd2, BRANCH = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [1:0]  ex_op = '0;
   logic [31:0] alu_result = '0, store_data = '0, new_pc = '0;
   logic [5:0]  rd_in = '0;
   logic [3:0]  branch_in = '0, cond_in = '0;
   logic        set_cond = 1'b0;
   logic [3:0]  alu_cond;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        wb_valid, wb_we, br_taken, mem_err;
   logic [5:0]  wb_rd;
   logic [31:0] wb_data, br_target;

   int checks = 0;
   int errors = 0;
   logic [3:0] model_cond = '0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
      .alu_result(alu_result), .store_data(store_data), .new_pc(new_pc), .rd_in(rd_in),
      .branch_in(branch_in), .set_cond(set_cond), .cond_in(cond_in), .alu_cond(alu_cond),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
      .wb_rd(wb_rd), .wb_data(wb_data), .br_taken(br_taken), .br_target(br_target),
      .mem_err(mem_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One instruction from issue to result; delay = request cycles before ack (>TIMEOUT: none).
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] npc, input logic [5:0] rd, input logic [3:0] br,
                        input logic setc, input logic [3:0] cin, input int delay,
                        input logic [31:0] rdv);
      logic [3:0] old_cond;
      bit         acked;
      chk("ready_before_issue", ex_ready, 1'b1);
      ex_valid = 1'b1; ex_op = op; alu_result = a; store_data = sd; new_pc = npc;
      rd_in = rd; branch_in = br; set_cond = setc; cond_in = cin;
      old_cond = model_cond;
      if (setc) model_cond = cin;
      step();
      ex_valid = 1'b0; set_cond = 1'b0;
      chk("alu_cond", alu_cond, model_cond);
      if (op == ALU) begin
         chk("alu_wb_valid", wb_valid, 1'b1);
         chk("alu_wb_data", wb_data, a);
         chk("alu_wb_rd", wb_rd, rd);
         chk("alu_wb_we", wb_we, rd != 0);
         chk("alu_ready", ex_ready, 1'b1);
      end else if (op == BRANCH) begin
         chk("br_taken", br_taken, (br & old_cond) != 0);
         if ((br & old_cond) != 0) chk("br_target", br_target, npc);
         chk("br_no_wb", wb_valid, 1'b0);
      end else if (a % 4 != 0) begin
         chk("mis_err", mem_err, 1'b1);
         chk("mis_no_req", dmem_req, 1'b0);
         chk("mis_ready", ex_ready, 1'b1);
         chk("mis_no_wb", wb_valid, 1'b0);
      end else begin
         acked = 1'b0;
         for (int i = 1; i <= TIMEOUT; i++) begin
            chk("acc_req", dmem_req, 1'b1);
            chk("acc_stall", ex_ready, 1'b0);
            chk("acc_addr", dmem_addr, a);
            chk("acc_we", dmem_we, op == STORE);
            if (op == STORE) chk("acc_wdata", dmem_wdata, sd);
            chk("acc_no_wb", wb_valid, 1'b0);
            if (i == delay) begin
               dmem_ack = 1'b1;
               dmem_rdata = rdv;
            end
            step();
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            if (i == delay) begin
               acked = 1'b1;
               break;
            end
         end
         chk("end_req_low", dmem_req, 1'b0);
         chk("end_ready", ex_ready, 1'b1);
         if (acked) begin
            chk("ack_wb_valid", wb_valid, 1'b1);
            chk("ack_wb_we", wb_we, (op == LOAD) && rd != 0);
            chk("ack_no_err", mem_err, 1'b0);
            if (op == LOAD) begin
               chk("ack_wb_rd", wb_rd, rd);
               chk("ack_wb_data", wb_data, rdv);
            end
         end else begin
            chk("tmo_err", mem_err, 1'b1);
            chk("tmo_no_wb", wb_valid, 1'b0);
         end
      end
      // Pulses clear; a stray ack in idle (covers the late-ack case) does nothing.
      dmem_ack = 1'($urandom_range(0, 1));
      step();
      dmem_ack = 1'b0;
      chk("pulse_wb_clear", wb_valid, 1'b0);
      chk("pulse_br_clear", br_taken, 1'b0);
      chk("pulse_err_clear", mem_err, 1'b0);
      chk("idle_no_req", dmem_req, 1'b0);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_a;
      logic [5:0]  r_rd;

      #3;
      chk("rst_ready", ex_ready, 1'b1);
      chk("rst_cond", alu_cond, 4'd0);
      chk("rst_req", dmem_req, 1'b0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_br", br_taken, 1'b0);
      chk("rst_err", mem_err, 1'b0);
      step();
      rst_n = 1'b1;
      step();

      do_op(ALU, 32'h1234, 32'h0, 32'h0, 6'd5, 4'h0, 1'b0, 4'h0, 0, 32'h0);
      do_op(LOAD, 32'h40, 32'h0, 32'h0, 6'd7, 4'h0, 1'b0, 4'h0, 3, 32'hCAFE);
      do_op(STORE, 32'h42, 32'h55, 32'h0, 6'd0, 4'h0, 1'b0, 4'h0, 0, 32'h0);
      do_op(LOAD, 32'h80, 32'h0, 32'h0, 6'd9, 4'h0, 1'b0, 4'h0, TIMEOUT + 1, 32'h0);
      do_op(LOAD, 32'h84, 32'h0, 32'h0, 6'd3, 4'h0, 1'b0, 4'h0, TIMEOUT, 32'hBEEF);
      do_op(STORE, 32'h88, 32'hA5A5, 32'h0, 6'd4, 4'h0, 1'b0, 4'h0, 1, 32'h0);
      do_op(ALU, 32'h77, 32'h0, 32'h0, 6'd0, 4'h0, 1'b1, 4'b0010, 0, 32'h0);
      do_op(BRANCH, 32'h0, 32'h0, 32'h100, 6'd0, 4'b0010, 1'b0, 4'h0, 0, 32'h0);
      do_op(BRANCH, 32'h0, 32'h0, 32'h200, 6'd0, 4'b0100, 1'b1, 4'b0100, 0, 32'h0);

      // Async reset in the middle of an access.
      ex_valid = 1'b1; ex_op = LOAD; alu_result = 32'h90; rd_in = 6'd2;
      step();
      ex_valid = 1'b0;
      step();
      chk("pre_rst_req", dmem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_req_drop", dmem_req, 1'b0);
      chk("async_ready", ex_ready, 1'b1);
      chk("async_cond", alu_cond, 4'd0);
      model_cond = '0;
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", ex_ready, 1'b1);
      chk("post_rst_no_wb", wb_valid, 1'b0);

      for (int n = 0; n < 60; n++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         if ($urandom_range(0, 3) != 0) r_a[1:0] = 2'b00;
         r_rd = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom);
         do_op(r_op, r_a, $urandom, $urandom, r_rd, 4'($urandom), 1'($urandom),
               4'($urandom), int'($urandom_range(1, TIMEOUT + 2)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
